// File: rtl/cond_exec_if.sv
// rtl/cond_exec_if.sv - decoder-side bus into the conditional-execution and flag unit
interface cond_exec_if #(
  parameter int CTX_W = 1
);
  logic             Valid;
  logic [CTX_W-1:0] Ctx;
  logic [3:0]       Cond;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             MULW;
  logic             FPUW;
  logic             NoWrite;
  logic [1:0]       FlagW;
  logic [3:0]       ALUFlags;
  logic             McStart;
  logic             McDone;
  logic [CTX_W-1:0] McCtx;
  logic [3:0]       McFlags;
  logic [1:0]       McFlagW;
  logic             Stall;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             MULWrite;
  logic             FPUWrite;
  logic             C;
  logic [3:0]       Flags;
  logic             McErr;

  modport master (
    output Valid, Ctx, Cond, PCS, RegW, MemW, MULW, FPUW, NoWrite, FlagW, ALUFlags,
           McStart, McDone, McCtx, McFlags, McFlagW,
    input  Stall, PCSrc, RegWrite, MemWrite, MULWrite, FPUWrite, C, Flags, McErr
  );

  modport slave (
    input  Valid, Ctx, Cond, PCS, RegW, MemW, MULW, FPUW, NoWrite, FlagW, ALUFlags,
           McStart, McDone, McCtx, McFlags, McFlagW,
    output Stall, PCSrc, RegWrite, MemWrite, MULWrite, FPUWrite, C, Flags, McErr
  );
endinterface

// File: rtl/cond_exec_unit.sv
// rtl/cond_exec_unit.sv - per-context NZCV banks, ARM condition gating and
// multi-cycle flag-producer tracking with stall, forwarding and timeout
module cond_exec_unit #(
  parameter int CTX_W      = 1,
  parameter int FWD_EN     = 1,
  parameter int MC_TIMEOUT = 16
) (
  input  logic         CLK,
  input  logic         Reset,
  cond_exec_if.slave   bus
);
  localparam int NUM_CTX = 2 ** CTX_W;
  localparam int CNT_W   = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  typedef enum logic {IDLE, PEND} pend_state_t;

  logic [3:0]       bank_q [NUM_CTX];
  logic [3:0]       bank_d [NUM_CTX];
  pend_state_t      st_q   [NUM_CTX];
  pend_state_t      st_d   [NUM_CTX];
  logic [CNT_W-1:0] cnt_q  [NUM_CTX];
  logic [CNT_W-1:0] cnt_d  [NUM_CTX];
  logic             mc_err_q, mc_err_d;

  logic       mc_live, bypass, stall, cond_ok, exec;
  logic [3:0] eval_flags;

  function automatic logic [3:0] merge_flags(input logic [3:0] old_f, input logic [3:0] new_f,
                                             input logic [1:0] mask);
    return {mask[1] ? new_f[3:2] : old_f[3:2], mask[0] ? new_f[1:0] : old_f[1:0]};
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:    return z;
      4'd1:    return ~z;
      4'd2:    return c;
      4'd3:    return ~c;
      4'd4:    return n;
      4'd5:    return ~n;
      4'd6:    return v;
      4'd7:    return ~v;
      4'd8:    return c & ~z;
      4'd9:    return ~c | z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return ~z & (n == v);
      4'd13:   return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // A completion only counts while its context is actually waiting on it.
  always_comb begin
    mc_live    = bus.McDone && (st_q[bus.McCtx] == PEND);
    bypass     = (FWD_EN != 0) && mc_live && (bus.McCtx == bus.Ctx);
    eval_flags = bypass ? merge_flags(bank_q[bus.Ctx], bus.McFlags, bus.McFlagW)
                        : bank_q[bus.Ctx];
    stall      = bus.Valid && (st_q[bus.Ctx] == PEND) && !bypass;
    cond_ok    = cond_pass(bus.Cond, eval_flags);
    exec       = bus.Valid && !stall && cond_ok;
  end

  assign bus.Stall    = stall;
  assign bus.PCSrc    = bus.PCS  & exec;
  assign bus.RegWrite = bus.RegW & exec & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & exec;
  assign bus.MULWrite = bus.MULW & exec;
  assign bus.FPUWrite = bus.FPUW & exec;
  assign bus.C        = eval_flags[1];
  assign bus.Flags    = bank_q[bus.Ctx];
  assign bus.McErr    = mc_err_q;

  // Completion/timeout is applied first so the issuing instruction's own update wins.
  always_comb begin
    mc_err_d = mc_err_q;
    for (int i = 0; i < NUM_CTX; i++) begin
      bank_d[i] = bank_q[i];
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      if (st_q[i] == PEND) begin
        if (mc_live && (bus.McCtx == CTX_W'(i))) begin
          bank_d[i] = merge_flags(bank_q[i], bus.McFlags, bus.McFlagW);
          st_d[i]   = IDLE;
        end else if (cnt_q[i] == CNT_W'(MC_TIMEOUT - 1)) begin
          st_d[i]  = IDLE;
          mc_err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (exec && (bus.Ctx == CTX_W'(i))) begin
        if (!bus.McStart) begin
          bank_d[i] = merge_flags(bank_d[i], bus.ALUFlags, bus.FlagW);
        end else if (bus.FlagW != 2'b00) begin
          st_d[i]  = PEND;
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mc_err_q <= 1'b0;
      for (int i = 0; i < NUM_CTX; i++) begin
        bank_q[i] <= 4'b0000;
        st_q[i]   <= IDLE;
        cnt_q[i]  <= '0;
      end
    end else begin
      mc_err_q <= mc_err_d;
      for (int i = 0; i < NUM_CTX; i++) begin
        bank_q[i] <= bank_d[i];
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_cond_exec_unit.sv
// tb/tb_cond_exec_unit.sv - directed bench driving a forwarding and a
// non-forwarding instance with the same instruction stream
module tb_cond_exec_unit;
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  logic       valid, pcs, regw, memw, mulw, fpuw, nowrite, mcstart, mcdone;
  logic       ctx, mcctx;
  logic [3:0] cond, aluf, mcflags;
  logic [1:0] flagw, mcflagw;
  int checks = 0;
  int errors = 0;

  cond_exec_if #(.CTX_W(1)) ifa ();
  cond_exec_if #(.CTX_W(1)) ifb ();

  cond_exec_unit #(.CTX_W(1), .FWD_EN(1), .MC_TIMEOUT(16)) dut_a (.CLK(CLK), .Reset(Reset), .bus(ifa));
  cond_exec_unit #(.CTX_W(1), .FWD_EN(0), .MC_TIMEOUT(16)) dut_b (.CLK(CLK), .Reset(Reset), .bus(ifb));

  assign ifa.Valid = valid;    assign ifb.Valid = valid;
  assign ifa.Ctx = ctx;        assign ifb.Ctx = ctx;
  assign ifa.Cond = cond;      assign ifb.Cond = cond;
  assign ifa.PCS = pcs;        assign ifb.PCS = pcs;
  assign ifa.RegW = regw;      assign ifb.RegW = regw;
  assign ifa.MemW = memw;      assign ifb.MemW = memw;
  assign ifa.MULW = mulw;      assign ifb.MULW = mulw;
  assign ifa.FPUW = fpuw;      assign ifb.FPUW = fpuw;
  assign ifa.NoWrite = nowrite; assign ifb.NoWrite = nowrite;
  assign ifa.FlagW = flagw;    assign ifb.FlagW = flagw;
  assign ifa.ALUFlags = aluf;  assign ifb.ALUFlags = aluf;
  assign ifa.McStart = mcstart; assign ifb.McStart = mcstart;
  assign ifa.McDone = mcdone;  assign ifb.McDone = mcdone;
  assign ifa.McCtx = mcctx;    assign ifb.McCtx = mcctx;
  assign ifa.McFlags = mcflags; assign ifb.McFlags = mcflags;
  assign ifa.McFlagW = mcflagw; assign ifb.McFlagW = mcflagw;

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    valid = 0; ctx = 0; cond = 0; pcs = 0; regw = 0; memw = 0; mulw = 0; fpuw = 0;
    nowrite = 0; flagw = 0; aluf = 0; mcstart = 0; mcdone = 0; mcctx = 0;
    mcflags = 0; mcflagw = 0;
  endtask

  initial begin
    logic [15:0] exp_a, exp_b;
    clr();
    #1 Reset = 1'b1;
    #2;
    chk("rst_stall", 16'(ifa.Stall), 16'h0);
    chk("rst_flags", 16'(ifa.Flags), 16'h0);
    chk("rst_mcerr", 16'(ifb.McErr), 16'h0);
    tick();
    Reset = 1'b0;

    // ALU flag write, then EQ passes on Z=1
    valid = 1; ctx = 0; cond = 14; flagw = 2'b11; aluf = 4'b0100;
    #1 chk("t1_regw_off", 16'(ifa.RegWrite), 16'h0);
    tick();
    chk("t1_flags_a", 16'(ifa.Flags), 16'h4);
    chk("t1_flags_b", 16'(ifb.Flags), 16'h4);
    cond = 0; flagw = 0; regw = 1; pcs = 1; memw = 1;
    #1;
    chk("t1_regwrite", 16'(ifa.RegWrite), 16'h1);
    chk("t1_pcsrc", 16'(ifa.PCSrc), 16'h1);
    chk("t1_memwrite", 16'(ifb.MemWrite), 16'h1);
    nowrite = 1;
    #1;
    chk("t1_nowrite_reg", 16'(ifa.RegWrite), 16'h0);
    chk("t1_nowrite_mem", 16'(ifa.MemWrite), 16'h1);
    tick();

    // NE fails: no enable and no flag update
    clr(); valid = 1; cond = 1; flagw = 2'b11; aluf = 4'b0000; regw = 1;
    #1 chk("t2_regwrite", 16'(ifa.RegWrite), 16'h0);
    tick();
    chk("t2_flags", 16'(ifa.Flags), 16'h4);

    // Condition table with N=1 Z=0 C=0 V=0
    clr(); valid = 1; cond = 14; flagw = 2'b11; aluf = 4'b1000;
    tick();
    chk("tab1_flags", 16'(ifa.Flags), 16'h8);
    exp_a = 16'hEA9A;
    flagw = 0; regw = 1;
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      #1 chk($sformatf("tab1_cond%0d", i), 16'(ifa.RegWrite), 16'(exp_a[i]));
    end
    // Condition table with N=0 Z=0 C=1 V=1
    cond = 14; flagw = 2'b11; aluf = 4'b0011; regw = 0;
    tick();
    chk("tab2_flags", 16'(ifb.Flags), 16'h3);
    chk("tab2_carry", 16'(ifa.C), 16'h1);
    exp_b = 16'hE966;
    flagw = 0; regw = 1;
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      #1 chk($sformatf("tab2_cond%0d", i), 16'(ifb.RegWrite), 16'(exp_b[i]));
    end

    // Multi-cycle producer on ctx1 with dependant stall and completion
    clr(); valid = 1; ctx = 1; cond = 14; mcstart = 1; flagw = 2'b10;
    #1 chk("t3_issue_stall", 16'(ifa.Stall), 16'h0);
    tick();
    mcstart = 0; flagw = 0; cond = 0; regw = 1;
    #1;
    chk("t3_stall1", 16'(ifa.Stall), 16'h1);
    chk("t3_stall1_reg", 16'(ifa.RegWrite), 16'h0);
    tick();
    ctx = 0; cond = 14;
    #1;
    chk("t3_ctx0_stall", 16'(ifa.Stall), 16'h0);
    chk("t3_ctx0_reg", 16'(ifa.RegWrite), 16'h1);
    tick();
    ctx = 1; cond = 0;
    #1 chk("t3_stall3", 16'(ifa.Stall), 16'h1);
    tick();
    mcdone = 1; mcctx = 1; mcflags = 4'b0100; mcflagw = 2'b10;
    #1;
    chk("t3_fwd_stall", 16'(ifa.Stall), 16'h0);
    chk("t3_fwd_reg", 16'(ifa.RegWrite), 16'h1);
    chk("t4_nofwd_stall", 16'(ifb.Stall), 16'h1);
    chk("t4_nofwd_reg", 16'(ifb.RegWrite), 16'h0);
    tick();
    mcdone = 0;
    #1;
    chk("t3_flags_ctx1", 16'(ifa.Flags), 16'h4);
    chk("t4_flags_ctx1", 16'(ifb.Flags), 16'h4);
    chk("t4_late_stall", 16'(ifb.Stall), 16'h0);
    chk("t4_late_reg", 16'(ifb.RegWrite), 16'h1);

    // Completion on ctx1 alongside an ALU write on ctx0
    clr(); valid = 1; ctx = 1; cond = 14; mcstart = 1; flagw = 2'b11;
    tick();
    clr(); valid = 1; ctx = 0; cond = 14; flagw = 2'b11; aluf = 4'b0010;
    mcdone = 1; mcctx = 1; mcflags = 4'b1001; mcflagw = 2'b11;
    #1 chk("both_ctx0_stall", 16'(ifa.Stall), 16'h0);
    tick();
    clr();
    #1 chk("both_ctx0_flags", 16'(ifa.Flags), 16'h2);
    ctx = 1;
    #1;
    chk("both_ctx1_flags_a", 16'(ifa.Flags), 16'h9);
    chk("both_ctx1_flags_b", 16'(ifb.Flags), 16'h9);

    // Timeout: sixteen pending cycles without completion
    clr(); valid = 1; ctx = 1; cond = 14; mcstart = 1; flagw = 2'b01;
    tick();
    mcstart = 0; flagw = 0; regw = 1;
    repeat (15) tick();
    chk("t5_pre_err", 16'(ifa.McErr), 16'h0);
    chk("t5_pre_stall", 16'(ifa.Stall), 16'h1);
    tick();
    chk("t5_err_a", 16'(ifa.McErr), 16'h1);
    chk("t5_err_b", 16'(ifb.McErr), 16'h1);
    chk("t5_stall_drop", 16'(ifa.Stall), 16'h0);
    chk("t5_reg_after", 16'(ifa.RegWrite), 16'h1);
    clr(); ctx = 1; mcdone = 1; mcctx = 1; mcflags = 4'b1111; mcflagw = 2'b11;
    tick();
    mcdone = 0;
    #1;
    chk("t5_ignored_done", 16'(ifa.Flags), 16'h9);
    chk("t5_err_sticky", 16'(ifa.McErr), 16'h1);

    // Asynchronous reset while a producer is outstanding
    clr(); valid = 1; ctx = 1; cond = 14; mcstart = 1; flagw = 2'b11;
    tick();
    mcstart = 0; flagw = 0; regw = 1;
    #1 chk("t6_pre_stall", 16'(ifa.Stall), 16'h1);
    Reset = 1'b1;
    #1;
    chk("t6_stall", 16'(ifa.Stall), 16'h0);
    chk("t6_flags", 16'(ifa.Flags), 16'h0);
    chk("t6_mcerr", 16'(ifa.McErr), 16'h0);
    chk("t6_stall_b", 16'(ifb.Stall), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
